// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
// Pure declarations; no latency or flow control.
// No backpressure: constant functions and state encoding only.
package tt_sweep_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        DRIVE = ST_DRIVE,
        DONE  = ST_DONE
    } state_t;

    // Ceiling log2, evaluated at elaboration for counter widths.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic logic [7:0] bin2gray(input logic [7:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/tt_dwell_counter.sv
// Dwell timer: counts 0..DWELL-1 while enabled, tc marks the final count.
// Latency: tc is combinational from the registered count (same cycle).
// No backpressure: clr has priority over en; wraps to 0 after the final count.
module tt_dwell_counter
    import tt_sweep_pkg::*;
#(
    parameter int DWELL = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int            CW   = (DWELL > 1) ? clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tc = en && (cnt == LAST);

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep of a combinational DUT; TT_SWEEP_GRAY_EN selects Gray-ordered stimulus.
// Latency: busy one cycle after start, done after 2**N_IN*DWELL busy cycles.
// No backpressure: start honoured only when not sweeping; abort cancels a sweep at once.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int                      N_IN   = 3,
    parameter int                      DWELL  = 20,
    parameter logic [(1<<N_IN)-1:0]    EXPECT = 8'b1110_1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            dut_out,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);

    localparam logic [N_IN-1:0] LAST_IDX = '1;

    state_t          state, state_nxt;
    logic [N_IN-1:0] index;
    logic            tc;
    logic            dwell_clr;
    logic            dwell_en;
    logic            launch;
    logic            compare;
    logic            last_cmp;

    assign dwell_en  = (state == DRIVE);
    assign dwell_clr = (state != DRIVE) || abort;
    assign launch    = (state != DRIVE) && start;
    // abort wins over a compare landing on the same edge
    assign compare   = (state == DRIVE) && tc && !abort;
    assign last_cmp  = compare && (index == LAST_IDX);

    tt_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (dwell_clr),
        .en    (dwell_en),
        .tc    (tc)
    );

`ifdef TT_SWEEP_GRAY_EN
    assign stim = N_IN'(bin2gray(8'(index)));
`else
    assign stim = index;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = DRIVE;
            end
            DRIVE: begin
                busy = 1'b1;
                if (abort)         state_nxt = IDLE;
                else if (last_cmp) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = DRIVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pass = done && (err_count == '0);

    // Results survive an abort; only a new start clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index           <= '0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if (launch) begin
            index           <= '0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if ((state == DRIVE) && abort) begin
            index <= '0;
        end else if (compare) begin
            if (dut_out != EXPECT[stim]) begin
                err_count <= err_count + 1'b1;
                if (!first_err_valid) begin
                    first_err_vec   <= stim;
                    first_err_valid <= 1'b1;
                end
            end
            // the last vector stays on stim while DONE
            if (!last_cmp) begin
                index <= index + 1'b1;
            end
        end
    end

endmodule
